// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU constants: op codes, controller state encodings and default latencies.
package mdu_issue_ctrl_pkg;

  localparam int unsigned MDU_OP_W        = 4;
  localparam int unsigned MDU_MUL_LAT_DEF = 5;
  localparam int unsigned MDU_DIV_LAT_DEF = 10;
  localparam int unsigned MDU_CNT_W_DEF   = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    MDU_ST_IDLE = 1'b0,
    MDU_ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_long(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || mdu_is_div(op);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat_counter.sv
// Loadable down-counter timing MDU latency; flags the final cycle (cnt==1).
module mdu_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/sequencing controller: start pulses, latency timing, HI/LO commit and D-stage stall.
// Optional MDU_DIV0_FAST_EN: divides by zero complete one cycle after issue.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MDU_MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = MDU_DIV_LAT_DEF,
  parameter int unsigned CNT_W   = MDU_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic [MDU_OP_W-1:0] op_type,
  input  logic                flush,
  input  logic                div_zero,
  input  logic                d_is_md,
  output logic                start,
  output logic [MDU_OP_W-1:0] start_op,
  output logic                hi_we,
  output logic                lo_we,
  output logic                commit,
  output logic                busy,
  output logic                stall_d
);

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LAT);

  mdu_state_e       state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_one;
  logic             div_zero_fast;

`ifdef MDU_DIV0_FAST_EN
  assign div_zero_fast = div_zero;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
  assign div_zero_fast   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ops arriving while RUN are protocol violations and are dropped silently.
  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    start_op     = MDU_NONE;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    commit       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      MDU_ST_IDLE: begin
        if (op_valid && !flush) begin
          if (mdu_is_long(op_type)) begin
            start    = 1'b1;
            start_op = op_type;
            cnt_load = 1'b1;
            state_d  = MDU_ST_RUN;
            if (mdu_is_div(op_type)) begin
              cnt_load_val = div_zero_fast ? CNT_W'(1) : DivLoad;
            end else begin
              cnt_load_val = MulLoad;
            end
          end
          hi_we = (op_type == MDU_MTHI);
          lo_we = (op_type == MDU_MTLO);
        end
      end
      MDU_ST_RUN: begin
        if (cnt_one) begin
          commit  = 1'b1;
          state_d = MDU_ST_IDLE;
        end
      end
      default: state_d = MDU_ST_IDLE;
    endcase
  end

  mdu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (state_q == MDU_ST_RUN),
    .one_o      (cnt_one)
  );

  assign busy    = start | (state_q == MDU_ST_RUN);
  assign stall_d = d_is_md & busy;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a commit-cycle scoreboard.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       op_valid = 1'b0;
  logic [3:0] op_type = 4'd0;
  logic       flush = 1'b0;
  logic       div_zero = 1'b0;
  logic       d_is_md = 1'b0;
  logic       start, hi_we, lo_we, commit, busy, stall_d;
  logic [3:0] start_op;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int exp_q[$];

  mdu_issue_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_type  (op_type),
    .flush    (flush),
    .div_zero (div_zero),
    .d_is_md  (d_is_md),
    .start    (start),
    .start_op (start_op),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .commit   (commit),
    .busy     (busy),
    .stall_d  (stall_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs == exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every commit must match the oldest expected commit cycle.
  always @(negedge clk) begin
    if (reset && commit) begin
      vecs++;
      assert (exp_q.size() != 0) else begin
        errs++;
        $error("FAIL commit_unexpected: observed commit at cycle %0d expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        vecs++;
        assert (cyc == e) else begin
          errs++;
          $error("FAIL commit_cycle: observed %0d expected %0d", cyc, e);
        end
      end
    end
  end

  // Protocol monitor: no long op or mt* may reach E while the MDU is running.
  always @(negedge clk) begin
    if (reset && busy && !start && op_valid && !flush) begin
      assert (!(mdu_is_long(op_type) || op_type == MDU_MTHI || op_type == MDU_MTLO)) else begin
        errs++;
        $error("FAIL protocol: observed op %0d in E while busy expected none", op_type);
      end
    end
  end

  initial begin
    int t;
    // Reset state
    d_is_md = 1'b1;
    #2;
    chk1("rst_start", start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_commit", commit, 1'b0);
    chk1("rst_stall", stall_d, 1'b0);
    chk4("rst_start_op", start_op, 4'd0);
    d_is_md = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // 1: mult, latency 5
    tick();
    op_valid = 1'b1; op_type = MDU_MULT;
    sample();
    t = cyc;
    chk1("t1_start", start, 1'b1);
    chk4("t1_start_op", start_op, MDU_MULT);
    chk1("t1_busy", busy, 1'b1);
    exp_q.push_back(t + 5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) op_valid = 1'b0;
      sample();
      chk1("t1_run_busy", busy, 1'b1);
      chk1("t1_run_start", start, 1'b0);
      chk1("t1_commit", commit, i == 5);
    end
    tick();
    sample();
    chk1("t1_idle_busy", busy, 1'b0);

    // 2: divu with mflo waiting in D
    tick();
    op_valid = 1'b1; op_type = MDU_DIVU;
    sample();
    t = cyc;
    chk1("t2_start", start, 1'b1);
    chk4("t2_start_op", start_op, MDU_DIVU);
    exp_q.push_back(t + 10);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin op_valid = 1'b0; d_is_md = 1'b1; end
      sample();
      chk1("t2_stall", stall_d, 1'b1);
      chk1("t2_commit", commit, i == 10);
    end
    tick();
    sample();
    chk1("t2_stall_release", stall_d, 1'b0);
    tick();
    d_is_md = 1'b0; op_valid = 1'b1; op_type = MDU_MFLO;
    sample();
    chk1("t2_mflo_start", start, 1'b0);
    chk1("t2_mflo_busy", busy, 1'b0);

    // 3: flush in the issue cycle
    tick();
    op_valid = 1'b1; op_type = MDU_MULT; flush = 1'b1;
    sample();
    chk1("t3_start", start, 1'b0);
    chk1("t3_busy", busy, 1'b0);
    chk4("t3_start_op", start_op, 4'd0);
    tick();
    op_type = MDU_MTHI;
    sample();
    chk1("t3_hi_we", hi_we, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      op_valid = 1'b0; flush = 1'b0;
      sample();
      chk1("t3_no_commit", commit, 1'b0);
      chk1("t3_idle", busy, 1'b0);
    end

    // 4: flush during RUN has no effect; then mtlo
    tick();
    op_valid = 1'b1; op_type = MDU_DIV;
    sample();
    t = cyc;
    chk1("t4_start", start, 1'b1);
    exp_q.push_back(t + 10);
    for (int i = 1; i <= 10; i++) begin
      tick();
      op_valid = 1'b0;
      flush = (i == 3);
      sample();
      chk1("t4_commit", commit, i == 10);
    end
    tick();
    flush = 1'b0; op_valid = 1'b1; op_type = MDU_MTLO;
    sample();
    chk1("t4_lo_we", lo_we, 1'b1);
    chk1("t4_hi_we", hi_we, 1'b0);
    chk1("t4_mt_start", start, 1'b0);
    tick();
    op_type = MDU_MTHI;
    sample();
    chk1("t4_hi_we_mthi", hi_we, 1'b1);
    chk1("t4_lo_we_mthi", lo_we, 1'b0);

    // 5: asynchronous reset mid-mult discards it
    tick();
    op_valid = 1'b1; op_type = MDU_MULTU;
    sample();
    t = cyc;
    chk1("t5_start", start, 1'b1);
    exp_q.push_back(t + 5);
    tick();
    op_valid = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_commit", commit, 1'b0);
    chk1("t5_rst_start", start, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk1("t5_after_rst_commit", commit, 1'b0);
      tick();
    end
    op_valid = 1'b1; op_type = MDU_MULT;
    sample();
    t = cyc;
    chk1("t5_reissue_start", start, 1'b1);
    exp_q.push_back(t + 5);
    for (int i = 1; i <= 6; i++) begin
      tick();
      op_valid = 1'b0;
      sample();
      chk1("t5_commit", commit, i == 5);
      chk1("t5_busy", busy, i <= 5);
    end

    // 6: divide by zero
    tick();
    op_valid = 1'b1; op_type = MDU_DIV; div_zero = 1'b1;
    sample();
    t = cyc;
    chk1("t6_start", start, 1'b1);
`ifdef MDU_DIV0_FAST_EN
    exp_q.push_back(t + 1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      op_valid = 1'b0; div_zero = 1'b0;
      sample();
      chk1("t6_commit", commit, i == 1);
      chk1("t6_busy", busy, i == 1);
    end
`else
    exp_q.push_back(t + 10);
    for (int i = 1; i <= 11; i++) begin
      tick();
      op_valid = 1'b0; div_zero = 1'b0;
      sample();
      chk1("t6_commit", commit, i == 10);
      chk1("t6_busy", busy, i <= 10);
    end
`endif

    repeat (3) tick();
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequencing controller for the multiply/divide unit in the 5-stage pipeline.
- Accepts MDU ops from the E stage and issues start pulses to the MDU datapath.
- Times mult/div latency, emits the HI/LO commit strobe and direct mthi/mtlo write enables.
- Generates the D-stage stall for MDU hazards; honours the exception flush at issue.

Parameters:
- MUL_LAT, 5, cycles from mult/multu issue to commit
- DIV_LAT, 10, cycles from div/divu issue to commit
- CNT_W, 4, latency counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- op_valid  in  1  E-stage instruction is an MDU op
- op_type  in  4  MDU op code (MDU_mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
- flush  in  1  exception/interrupt request this cycle; cancels the E-stage op
- div_zero  in  1  divisor of the E-stage op is zero (used only with the optional feature)
- d_is_md  in  1  D-stage instruction is any MDU op
- start  out  1  issue pulse to the datapath; the datapath samples operands at this edge
- start_op  out  4  op type qualified by start, 0 otherwise
- hi_we  out  1  mthi write enable
- lo_we  out  1  mtlo write enable
- commit  out  1  datapath copies its hi_tmp/lo_tmp into HI/LO at this edge
- busy  out  1  MDU occupied
- stall_d  out  1  freeze the F/D stages and insert a bubble into E

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, cnt=0. start, hi_we, lo_we, commit and busy are 0, and stall_d=0 apart from any d_is_md term. An in-flight op is discarded with no commit.
- States:
  - IDLE: no op in flight.
  - RUN: counting latency.
- Long op: op_valid & op_type ∈ {mult, multu, div, divu}.
- Issue condition: issue = op_valid & long op & state==IDLE & !flush. All of these outputs are combinational in the issue cycle T:
  - start=1
  - start_op=op_type
- Next-state on issue: cnt<=MUL_LAT for mult/multu, DIV_LAT for div/divu; state<=RUN.
- RUN: cnt decrements each cycle. commit=1 (combinational) when state==RUN & cnt==1. At that edge state<=IDLE and cnt<=0.
- Timing: commit occurs in cycle T+LAT, and HI/LO are visible from cycle T+LAT+1.
- busy = start | (state==RUN), so it is high in cycles T..T+LAT.
- stall_d = d_is_md & busy. This blocks mfhi/mflo/mthi/mtlo and back-to-back long ops until HI/LO are committed.
- mthi/mtlo: hi_we/lo_we = op_valid & op matches & state==IDLE & !flush, combinational. They never coincide with commit.
- mfhi/mflo: no controller action; read hazard is covered by stall_d.
- flush:
  - In the issue cycle, it suppresses start, hi_we and lo_we. State stays IDLE.
  - During RUN it has no effect: the in-flight op completes and commits, per MIPS precise-exception rules for already-issued MDU ops.
- Protocol violation: op_valid with a long op or mt* while state==RUN cannot occur under stall_d. If it does, it is ignored (no start, no we). The bench flags it with an assertion.
- Simultaneous commit and new op in E: impossible by stall_d. The next issue is accepted in cycle T+LAT+1 at the earliest.

Optional Feature:
- MDU_DIV0_FAST_EN defined: a div/divu issued with div_zero=1 loads cnt=1, so commit occurs in cycle T+1 and busy lasts 2 cycles. The datapath result is architecturally undefined but committed.
- Undefined: div_zero is ignored and every divide takes DIV_LAT.

Decomposition:
- Shared constants file (the existing shared constants include) holds:
  - MDU op codes
  - state encodings MDU_ST_IDLE / MDU_ST_RUN
  - default MUL_LAT / DIV_LAT
- One sub-module: mdu_lat_counter (load value, load strobe, decrement, cnt==1 flag, async active-low clear).

Test Plan:
1. mult issued at T with flush=0 -> start=1 at T; busy high T..T+5; commit only at T+5; state IDLE at T+6.
2. divu then mflo in D at T+1 -> stall_d=1 for T+1..T+10; commit at T+10; stall_d=0 at T+11.
3. mult with flush=1 in issue cycle -> start=0, busy=0, no commit in the following 10 cycles; mthi with flush=1 -> hi_we=0.
4. flush at T+3 of an in-flight div -> commit still at T+10; mtlo with flush=0 in IDLE -> lo_we=1 same cycle.
5. reset driven to 0 at T+2 of a mult -> all outputs 0 immediately, no commit; after release, a new mult issues normally with commit at +5.
6. With MDU_DIV0_FAST_EN, div with div_zero=1 -> commit at T+1, busy T..T+1. Without the macro -> commit at T+10.
